accum_warp_looper_bank_issue: RTL and testbench
===============================================

ACCUM_WARP_LOOPER_BANK_ISSUE -- requirements
Module: AccumWarpLooperBankIssue

Interface
REQ-001 SHALL have parameters: N_CFG, default TauCfg::N_ICFG, number of configs; ABW, default TauCfg::GLOBAL_ADDR_BW, address width; VSIZE, default TauCfg::VSIZE, lanes per bundle; NBANK = VSIZE (power of 2), SRAM banks; BBW = log2(NBANK); NCFG_BW = $clog2(N_CFG+1).
REQ-002 SHALL have ports:
- i_clk  in  1  sole clock, all state on rising edge
- i_rst  in  1  reset, synchronous, active-high
- src_rdy  in  1  upstream vector bundle offered
- src_ack  out  1  bundle accepted this cycle
- i_id  in  NCFG_BW  config id
- i_address  in  ABW x VSIZE  per-lane address
- i_valid  in  VSIZE  lane valid mask
- i_retire  in  1  bundle retire flag
- i_fin_dval  in  1  upstream fin pulse; coincides with src_ack of the final bundle
- dst_rdy  out  1  bank beat offered
- dst_ack  in  1  beat consumed; only honoured when dst_rdy=1
- o_id  out  NCFG_BW  id of the bundle being issued
- o_bank_addr  out  (ABW-BBW) x NBANK  row address per bank
- o_bank_lane  out  log2(VSIZE) x NBANK  source lane per bank
- o_bank_valid  out  NBANK  bank request mask
- o_last  out  1  final beat of the current bundle
- o_retire  out  1  i_retire of the bundle, asserted only on its last beat
- fin_dval  out  1  one-cycle pulse on acked last beat of the fin-tagged bundle

Function
REQ-003 SHALL hold one bundle register (id, addresses, retire, fin tag) and a pending lane mask; state IDLE (no bundle) or BUSY.
REQ-004 SHALL set src_ack = src_rdy && (IDLE || (dst_ack && o_last)); a new bundle is accepted in the same cycle the previous bundle's last beat is acked.
REQ-005 On src_ack SHALL load pending = i_valid, latch i_id/i_address/i_retire, fin tag = i_fin_dval, and enter BUSY; dst_rdy is first asserted the next cycle (latency 1).
REQ-006 SHALL assert dst_rdy = BUSY; all beat outputs are combinational from registered state only, with no path from src_rdy or dst_ack.
REQ-007 Bank of lane i SHALL be address[i][BBW-1:0]; row SHALL be address[i][ABW-1:BBW].
REQ-008 Per beat, for each bank b, SHALL select the lowest-index pending lane mapping to b: o_bank_valid[b]=1, o_bank_lane[b]=lane, o_bank_addr[b]=row; banks with no pending lane drive valid 0, lane 0, addr 0.
REQ-009 o_last SHALL be 1 when pending with the selected lanes removed is zero.
REQ-010 On dst_ack SHALL clear the selected lanes from pending; if o_last, return to IDLE unless a new bundle is accepted the same cycle.
REQ-011 Beats per bundle SHALL equal the maximum number of valid lanes sharing one bank, minimum 1.
REQ-012 A bundle with i_valid = 0 SHALL produce exactly one beat with o_bank_valid = 0 and o_last = 1; retire and fin are still delivered.
REQ-013 o_retire SHALL equal the latched retire AND o_last; fin_dval SHALL equal dst_ack AND o_last AND fin tag.
REQ-014 While dst_rdy && !dst_ack, all beat outputs SHALL hold stable.
REQ-015 Lanes with i_valid = 0 SHALL never be issued, whatever their address.

Reset
REQ-016 When i_rst=1 at a clock edge: state IDLE, pending 0, registered id/addresses/retire/fin tag 0; hence dst_rdy=0, o_bank_valid=0, o_last=0, o_retire=0, fin_dval=0, src_ack=0 in that cycle.
REQ-017 Reset mid-bundle SHALL discard the bundle with no further beats; the first post-reset bundle behaves per REQ-005.

Verification (VSIZE=NBANK=4, ABW=16)
REQ-018 Conflict-free: addresses 0x10,0x11,0x12,0x13, valid 1111 -> one beat next cycle; banks 0..3 valid, rows 4,4,4,4, lanes 0,1,2,3, o_last=1.
REQ-019 Full conflict: addresses 0x20,0x24,0x28,0x2C, valid 1111, retire=1 -> four beats on bank 0 only, lanes 0,1,2,3 in order, rows 8,9,10,11; o_retire=1 only on beat 4.
REQ-020 Backpressure and back-to-back: hold dst_ack=0 for 3 cycles mid-bundle -> outputs stable; the next bundle is src_acked in the same cycle as the last-beat ack; dst_rdy has no bubble.
REQ-021 Masked/empty: valid 0101 with all lanes on bank 2 -> two beats (lanes 0, 2); valid 0000 with i_fin_dval=1 -> one beat, bank_valid 0000, fin_dval pulses on its ack.
REQ-022 Reset asserted during beat 2 of the REQ-019 bundle -> dst_rdy=0 the next cycle; no fin_dval or retire seen; new bundle accepted normally.

Source files
------------

// File: rtl/accum_warp_looper_bank_issue.sv
// Bank-conflict issue stage for one vector bundle.
// A bundle of VSIZE lane addresses is latched. It is then issued as one or more
// bank beats. In each beat, every SRAM bank serves the lowest-index lane that is
// still pending and maps to that bank. The bundle finishes when no lanes remain.
// A new bundle may be accepted in the same cycle that the last beat is acked, so
// dst_rdy shows no bubble between bundles.
module accum_warp_looper_bank_issue #(
  parameter int N_CFG = 16,
  parameter int ABW   = 16,
  parameter int VSIZE = 4,
  localparam int NBANK   = VSIZE,
  localparam int BBW     = $clog2(NBANK),
  localparam int NCFG_BW = $clog2(N_CFG + 1),
  localparam int LBW     = $clog2(VSIZE),
  localparam int RBW     = ABW - BBW
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   src_rdy,
  output logic                   src_ack,
  input  logic [NCFG_BW-1:0]     i_id,
  input  logic [ABW*VSIZE-1:0]   i_address,
  input  logic [VSIZE-1:0]       i_valid,
  input  logic                   i_retire,
  input  logic                   i_fin_dval,
  output logic                   dst_rdy,
  input  logic                   dst_ack,
  output logic [NCFG_BW-1:0]     o_id,
  output logic [RBW*NBANK-1:0]   o_bank_addr,
  output logic [LBW*NBANK-1:0]   o_bank_lane,
  output logic [NBANK-1:0]       o_bank_valid,
  output logic                   o_last,
  output logic                   o_retire,
  output logic                   fin_dval
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Bundle register and the lanes still waiting to be issued
  state_t               state_reg,   state_next;
  logic [VSIZE-1:0]     pending_reg, pending_next;
  logic [NCFG_BW-1:0]   id_reg,      id_next;
  logic                 retire_reg,  retire_next;
  logic                 fin_reg,     fin_next;
  logic [ABW-1:0]       addr_reg  [VSIZE];
  logic [ABW-1:0]       addr_next [VSIZE];

  // Per-lane decode of the latched addresses
  logic [BBW-1:0]       lane_bank [VSIZE];
  logic [RBW-1:0]       lane_row  [VSIZE];

  // Lanes picked for the beat currently on the outputs
  logic [VSIZE-1:0]     sel_mask;
  logic [VSIZE-1:0]     remain_mask;
  logic                 busy;
  logic                 last_beat;
  logic                 load;

  assign busy = (state_reg == BUSY);

  // Lane decode and selection. A pending lane is issued this beat only when no
  // lower-index pending lane targets the same bank. That rule gives each bank at
  // most one lane per beat and keeps the lowest index first.
  genvar gi, gj;
  generate
    for (gi = 0; gi < VSIZE; gi++) begin : g_lane
      logic [VSIZE-1:0] conflict;

      assign lane_bank[gi] = addr_reg[gi][BBW-1:0];
      assign lane_row[gi]  = addr_reg[gi][ABW-1:BBW];

      for (gj = 0; gj < VSIZE; gj++) begin : g_cmp
        if (gj < gi) begin : g_lower
          assign conflict[gj] = pending_reg[gj] && (lane_bank[gj] == lane_bank[gi]);
        end else begin : g_upper
          assign conflict[gj] = 1'b0;
        end
      end

      assign sel_mask[gi] = pending_reg[gi] && !(|conflict);
    end
  endgenerate

  assign remain_mask = pending_reg & ~sel_mask;
  assign last_beat   = busy && (remain_mask == '0);

  // Per-bank output mux. The selection guarantees at most one hit per bank, so
  // OR-reducing the hit lanes gives that lane's index and row. A bank with no
  // hit drives zeros.
  generate
    for (gi = 0; gi < NBANK; gi++) begin : g_bank
      logic [VSIZE-1:0] hit;
      logic [LBW-1:0]   lane_sel;
      logic [RBW-1:0]   row_sel;

      for (gj = 0; gj < VSIZE; gj++) begin : g_hit
        assign hit[gj] = sel_mask[gj] && (lane_bank[gj] == BBW'(gi));
      end

      // Fold the single hit lane into its index and row
      always_comb begin
        lane_sel = '0;
        row_sel  = '0;
        for (int l = 0; l < VSIZE; l++) begin
          if (hit[l]) begin
            lane_sel = lane_sel | LBW'(l);
            row_sel  = row_sel | lane_row[l];
          end
        end
      end

      assign o_bank_valid[gi]              = |hit;
      assign o_bank_lane[gi*LBW +: LBW]    = lane_sel;
      assign o_bank_addr[gi*RBW +: RBW]    = row_sel;
    end
  endgenerate

  // Beat outputs depend only on registered state. The handshake outputs are
  // forced low while reset is asserted, so a bundle that is being discarded
  // cannot complete.
  assign dst_rdy  = busy;
  assign o_id     = id_reg;
  assign o_last   = last_beat;
  assign o_retire = retire_reg && last_beat;
  assign src_ack  = !i_rst && src_rdy && (!busy || (dst_ack && last_beat));
  assign fin_dval = !i_rst && dst_ack && last_beat && fin_reg;
  assign load     = src_ack;

  // Next-state: load a new bundle, retire issued lanes on an ack, or hold
  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    id_next      = id_reg;
    retire_next  = retire_reg;
    fin_next     = fin_reg;
    for (int i = 0; i < VSIZE; i++) begin
      addr_next[i] = addr_reg[i];
    end

    if (load) begin
      state_next   = BUSY;
      pending_next = i_valid;
      id_next      = i_id;
      retire_next  = i_retire;
      fin_next     = i_fin_dval;
      for (int i = 0; i < VSIZE; i++) begin
        addr_next[i] = i_address[i*ABW +: ABW];
      end
    end else if (busy && dst_ack) begin
      pending_next = remain_mask;
      if (last_beat) begin
        state_next = IDLE;
      end
    end
  end

  // State register; reset drops any bundle in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      id_reg      <= '0;
      retire_reg  <= 1'b0;
      fin_reg     <= 1'b0;
      for (int i = 0; i < VSIZE; i++) begin
        addr_reg[i] <= '0;
      end
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      id_reg      <= id_next;
      retire_reg  <= retire_next;
      fin_reg     <= fin_next;
      for (int i = 0; i < VSIZE; i++) begin
        addr_reg[i] <= addr_next[i];
      end
    end
  end

endmodule

// File: tb/tb_accum_warp_looper_bank_issue.sv
// Self-checking bench for accum_warp_looper_bank_issue (VSIZE=4, ABW=16).
// The expected beats of every accepted bundle are queued. The queue is checked
// against the DUT on every falling edge.
module tb_accum_warp_looper_bank_issue;

  localparam int ABW = 16;
  localparam int VS  = 4;
  localparam int IDW = 5;
  localparam int RBW = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic              src_rdy;
  logic              src_ack;
  logic [IDW-1:0]    i_id;
  logic [ABW*VS-1:0] i_address;
  logic [VS-1:0]     i_valid;
  logic              i_retire;
  logic              i_fin_dval;
  logic              dst_rdy;
  logic              dst_ack;
  logic [IDW-1:0]    o_id;
  logic [RBW*VS-1:0] o_bank_addr;
  logic [2*VS-1:0]   o_bank_lane;
  logic [VS-1:0]     o_bank_valid;
  logic              o_last;
  logic              o_retire;
  logic              fin_dval;

  logic hold_ack = 1'b0;
  logic ack_rand = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [IDW-1:0]    id;
    logic [VS-1:0]     bv;
    logic [2*VS-1:0]   lanes;
    logic [RBW*VS-1:0] rows;
    logic              last;
    logic              retire;
    logic              fin;
  } beat_t;

  beat_t exp_q[$];

  accum_warp_looper_bank_issue #(.N_CFG(16), .ABW(ABW), .VSIZE(VS)) dut (
    .i_clk(clk), .i_rst(rst), .src_rdy(src_rdy), .src_ack(src_ack),
    .i_id(i_id), .i_address(i_address), .i_valid(i_valid), .i_retire(i_retire),
    .i_fin_dval(i_fin_dval), .dst_rdy(dst_rdy), .dst_ack(dst_ack), .o_id(o_id),
    .o_bank_addr(o_bank_addr), .o_bank_lane(o_bank_lane), .o_bank_valid(o_bank_valid),
    .o_last(o_last), .o_retire(o_retire), .fin_dval(fin_dval)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: each bank takes the lowest pending lane that maps to it
  task automatic push_bundle(input logic [IDW-1:0] id, input logic [ABW*VS-1:0] addr,
                             input logic [VS-1:0] v, input logic ret, input logic fin);
    logic [VS-1:0]  pend;
    logic [VS-1:0]  sel;
    logic [ABW-1:0] a;
    beat_t          bt;
    pend = v;
    for (int n = 0; n <= VS; n++) begin
      bt = '0;
      bt.id = id;
      bt.fin = fin;
      sel = '0;
      for (int b = 0; b < VS; b++) begin
        for (int i = 0; i < VS; i++) begin
          a = addr[i*ABW +: ABW];
          if (pend[i] && !bt.bv[b] && (a[1:0] == b[1:0])) begin
            bt.bv[b] = 1'b1;
            bt.lanes[b*2 +: 2] = i[1:0];
            bt.rows[b*RBW +: RBW] = a[ABW-1:2];
            sel[i] = 1'b1;
          end
        end
      end
      pend = pend & ~sel;
      bt.last = (pend == '0);
      bt.retire = ret && bt.last;
      exp_q.push_back(bt);
      if (bt.last) break;
    end
  endtask

  // Scoreboard monitor, one comparison set per falling edge
  always @(negedge clk) begin
    beat_t f;
    logic  has;
    if (rst) begin
      check("rst_src_ack", src_ack, 1'b0);
      check("rst_fin_dval", fin_dval, 1'b0);
      exp_q.delete();
    end else begin
      has = (exp_q.size() > 0);
      f = has ? exp_q[0] : '0;
      check("dst_rdy", dst_rdy, has);
      check("src_ack", src_ack, src_rdy && (!has || (dst_ack && f.last)));
      check("fin_dval", fin_dval, has && dst_ack && f.last && f.fin);
      if (has) begin
        $display("beat id=%0d bv=%b lanes=%h last=%b ret=%b ack=%b",
                 o_id, o_bank_valid, o_bank_lane, o_last, o_retire, dst_ack);
        check("o_id", o_id, f.id);
        check("o_bank_valid", o_bank_valid, f.bv);
        check("o_bank_lane", o_bank_lane, f.lanes);
        check("o_bank_addr", o_bank_addr, f.rows);
        check("o_last", o_last, f.last);
        check("o_retire", o_retire, f.retire);
        if (dst_ack) void'(exp_q.pop_front());
      end
      if (src_ack) push_bundle(i_id, i_address, i_valid, i_retire, i_fin_dval);
    end
  end

  // Sink: always ready, held off on request, or random
  initial begin
    dst_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_ack) dst_ack = 1'b0;
      else if (ack_rand) dst_ack = ($urandom_range(0, 2) != 0);
      else dst_ack = 1'b1;
    end
  end

  task automatic send(input logic [IDW-1:0] id, input logic [15:0] a0, input logic [15:0] a1,
                      input logic [15:0] a2, input logic [15:0] a3, input logic [VS-1:0] v,
                      input logic ret, input logic fin);
    logic acc;
    acc = 1'b0;
    i_id = id;
    i_address = {a3, a2, a1, a0};
    i_valid = v;
    i_retire = ret;
    i_fin_dval = fin;
    src_rdy = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (src_ack) begin
        acc = 1'b1;
        break;
      end
    end
    if (!acc) check("send_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    src_rdy = 1'b0;
    i_fin_dval = 1'b0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !dst_rdy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("drain_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    src_rdy = 1'b0;
    i_id = '0;
    i_address = '0;
    i_valid = '0;
    i_retire = 1'b0;
    i_fin_dval = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    src_rdy = 1'b1;
    @(negedge clk);
    check("reset_dst_rdy", dst_rdy, 1'b0);
    check("reset_bank_valid", o_bank_valid, 4'b0000);
    check("reset_o_last", o_last, 1'b0);
    check("reset_o_retire", o_retire, 1'b0);
    check("reset_src_ack", src_ack, 1'b0);
    @(posedge clk);
    #1;
    src_rdy = 1'b0;
    rst = 1'b0;

    // Conflict-free bundle: single beat, all four banks
    send(5'd1, 16'h0010, 16'h0011, 16'h0012, 16'h0013, 4'b1111, 1'b0, 1'b0);
    @(negedge clk);
    check("cf_bank_valid", o_bank_valid, 4'b1111);
    check("cf_lanes", o_bank_lane, 8'hE4);
    check("cf_rows", o_bank_addr, {14'd4, 14'd4, 14'd4, 14'd4});
    check("cf_last", o_last, 1'b1);
    wait_idle();

    // Full conflict on bank 0 with retire: four beats
    send(5'd2, 16'h0020, 16'h0024, 16'h0028, 16'h002C, 4'b1111, 1'b1, 1'b0);
    wait_idle();

    // Backpressure mid-bundle, then a back-to-back bundle
    send(5'd3, 16'h0020, 16'h0024, 16'h0028, 16'h002C, 4'b1111, 1'b1, 1'b0);
    fork
      begin
        @(posedge clk);
        hold_ack = 1'b1;
        repeat (3) @(posedge clk);
        hold_ack = 1'b0;
      end
    join_none
    send(5'd4, 16'h0010, 16'h0011, 16'h0012, 16'h0013, 4'b1111, 1'b0, 1'b1);
    wait_idle();

    // Masked lanes all on bank 2, then an empty bundle tagged fin
    send(5'd5, 16'h0002, 16'h0006, 16'h000A, 16'h000E, 4'b0101, 1'b0, 1'b0);
    send(5'd6, 16'h1234, 16'h0000, 16'hFFFF, 16'h0005, 4'b0000, 1'b1, 1'b1);
    wait_idle();

    // Reset during beat 2 of a retire+fin bundle, then resume
    send(5'd7, 16'h0020, 16'h0024, 16'h0028, 16'h002C, 4'b1111, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_dst_rdy", dst_rdy, 1'b0);
    send(5'd8, 16'h0031, 16'h0035, 16'h0032, 16'h0033, 4'b1111, 1'b1, 1'b1);
    wait_idle();

    // Random bundles with a random sink; narrow addresses force bank conflicts
    ack_rand = 1'b1;
    for (int t = 0; t < 40; t++) begin
      send(5'($urandom_range(0, 16)),
           16'($urandom_range(0, 63)), 16'($urandom_range(0, 63)),
           16'($urandom_range(0, 63)), 16'($urandom_range(0, 63)),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    ack_rand = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
